// File: rtl/pixel_pack_pkg.sv
// Shared defaults, pad value, flush state type
// and lane-count width helper for pixel_pack_fifo.
package pixel_pack_pkg;

  localparam int DEF_PIXEL_WIDTH = 8;
  localparam int DEF_IN_LANES    = 3;
  localparam int DEF_OUT_LANES   = 4;
  localparam int DEF_ADDR_WIDTH  = 4;

  localparam logic [DEF_PIXEL_WIDTH-1:0] DEF_PAD_VALUE = '0;

  // bits needed to hold 0..OUT_LANES lanes
  localparam int LANE_CNT_W = $clog2(DEF_OUT_LANES + 1);

  typedef enum logic {
    ST_FILL,
    ST_FLUSH
  } pack_state_e;

endpackage

// File: rtl/lane_ram.sv
// Lane storage: IN_LANES write ports, OUT_LANES comb read ports.
// Ports: clk, we, wr_ptr, wdata, rd_ptr, rdata (mod-DEPTH addressing).
module lane_ram #(
  parameter int PW        = 8,
  parameter int IN_LANES  = 3,
  parameter int OUT_LANES = 4,
  parameter int AW        = 4
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           wr_ptr,
  input  logic [IN_LANES*PW-1:0]  wdata,
  input  logic [AW-1:0]           rd_ptr,
  output logic [OUT_LANES*PW-1:0] rdata
);

  localparam int DEPTH = 2**AW;

  logic [PW-1:0] mem [DEPTH];

  // lane 0 of wdata (MSBs) lands at wr_ptr
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < IN_LANES; i++) begin
        mem[wr_ptr + AW'(i)] <= wdata[(IN_LANES-1-i)*PW +: PW];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int j = 0; j < OUT_LANES; j++) begin
      rdata[(OUT_LANES-1-j)*PW +: PW] = mem[rd_ptr + AW'(j)];
    end
  end

endmodule

// File: rtl/pixel_pack_fifo.sv
// Lane-repacking FIFO: IN_LANES-wide writes, OUT_LANES-wide FWFT reads,
// eof flushes a padded final word (rd_last). Ports: clk, rst, din/wr_req/
// wr_vld, eof, dout/rd_req/rd_vld/rd_last, count (lanes stored).
module pixel_pack_fifo
  import pixel_pack_pkg::*;
#(
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int IN_LANES    = DEF_IN_LANES,
  parameter int OUT_LANES   = DEF_OUT_LANES,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter logic [PIXEL_WIDTH-1:0] PAD_VALUE =
    PIXEL_WIDTH'(DEF_PAD_VALUE)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [IN_LANES*PIXEL_WIDTH-1:0]  din,
  input  logic                             wr_req,
  output logic                             wr_vld,
  input  logic                             eof,
  output logic [OUT_LANES*PIXEL_WIDTH-1:0] dout,
  input  logic                             rd_req,
  output logic                             rd_vld,
  output logic                             rd_last,
  output logic [ADDR_WIDTH:0]              count
);

  localparam int PW    = PIXEL_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2**ADDR_WIDTH;

  pack_state_e           state, state_nx;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  flush_pending;
  logic                  wr_en, rd_en;
  logic [CW-1:0]         pop_n, count_next;
  logic [OUT_LANES*PW-1:0] head;

  assign flush_pending = (state == ST_FLUSH);

  // count never exceeds DEPTH, so the subtraction cannot wrap
  assign wr_vld = (CW'(DEPTH) - count >= CW'(IN_LANES)) && !flush_pending;
  assign rd_vld = (count >= CW'(OUT_LANES)) ||
                  (flush_pending && count != '0);
  assign rd_last = flush_pending && rd_vld &&
                   (count <= CW'(OUT_LANES));

  assign wr_en = wr_req && wr_vld;
  assign rd_en = rd_req && rd_vld;

  assign pop_n = !rd_en ? '0 :
                 (count >= CW'(OUT_LANES)) ? CW'(OUT_LANES) : count;

  assign count_next = count + (wr_en ? CW'(IN_LANES) : '0) - pop_n;

  lane_ram #(
    .PW        (PW),
    .IN_LANES  (IN_LANES),
    .OUT_LANES (OUT_LANES),
    .AW        (ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .we     (wr_en),
    .wr_ptr (wr_ptr),
    .wdata  (din),
    .rd_ptr (rd_ptr),
    .rdata  (head)
  );

  // lanes past count only appear in a flushed tail word
  always_comb begin
    dout = '0;
    if (rd_vld) begin
      for (int j = 0; j < OUT_LANES; j++) begin
        dout[(OUT_LANES-1-j)*PW +: PW] =
          (CW'(j) < count) ? head[(OUT_LANES-1-j)*PW +: PW] : PAD_VALUE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= ST_FILL;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ADDR_WIDTH'(IN_LANES);
      if (rd_en) rd_ptr <= rd_ptr + ADDR_WIDTH'(pop_n);
      count <= count_next;
      state <= state_nx;
    end
  end

  // flush ends when storage drains; an empty flush lasts one cycle
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_FILL:  if (eof) state_nx = ST_FLUSH;
      ST_FLUSH: if (count_next == '0) state_nx = ST_FILL;
      default:  state_nx = ST_FILL;
    endcase
  end

endmodule

// File: tb/tb_pixel_pack_fifo.sv
// Scoreboard bench for pixel_pack_fifo: lane-queue reference model,
// directed packing/full/wrap/flush/reset cases, then random traffic.
module tb_pixel_pack_fifo;

  localparam int PW = 8;
  localparam int IL = 3;
  localparam int OL = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [23:0]   din = '0;
  logic          wr_req = 1'b0;
  logic          wr_vld;
  logic          eof = 1'b0;
  logic [31:0]   dout;
  logic          rd_req = 1'b0;
  logic          rd_vld;
  logic          rd_last;
  logic [4:0]    count;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mq[$];
  bit          mfp = 1'b0;
  bit          minit = 1'b0;
  logic [32:0] exp_q[$];
  logic [32:0] got_e;

  always #5 clk = ~clk;

  pixel_pack_fifo dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .wr_req  (wr_req),
    .wr_vld  (wr_vld),
    .eof     (eof),
    .dout    (dout),
    .rd_req  (rd_req),
    .rd_vld  (rd_vld),
    .rd_last (rd_last),
    .count   (count)
  );

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // monitor: every DUT pop must match the oldest predicted word
  always @(negedge clk) begin
    if (rst === 1'b0 && rd_vld === 1'b1 && rd_req === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: got %0h expected none",
                 {rd_last, dout});
      end else begin
        got_e = exp_q.pop_front();
        if ({rd_last, dout} !== got_e) begin
          errors++;
          $display("FAIL sb_word: got last=%0b %08h expected last=%0b %08h",
                   rd_last, dout, got_e[32], got_e[31:0]);
        end
      end
    end
  end

  // one clock: drive at posedge+1, check at negedge, update model at posedge
  task automatic step(input bit w, input logic [23:0] d, input bit r,
                      input bit e, input bit rs);
    int n;
    bit m_rv, m_wv, m_last, m_wr, m_rd;
    logic [31:0] xd;
    wr_req = w; din = d; rd_req = r; eof = e; rst = rs;
    n = mq.size();
    m_rv = (n >= OL) || (mfp && n > 0);
    m_wv = (DEPTH - n >= IL) && !mfp;
    m_last = mfp && m_rv && (n <= OL);
    xd = '0;
    if (m_rv)
      for (int j = 0; j < OL; j++)
        xd[(OL-1-j)*PW +: PW] = (j < n) ? mq[j] : 8'h00;
    m_wr = minit && w && m_wv;
    m_rd = minit && r && m_rv;
    if (m_rd && !rs) exp_q.push_back({m_last, xd});
    @(negedge clk);
    if (minit) begin
      chk("count", 64'(count), 64'(n));
      chk("wr_vld", 64'(wr_vld), 64'(m_wv));
      chk("rd_vld", 64'(rd_vld), 64'(m_rv));
      chk("rd_last", 64'(rd_last), 64'(m_last));
      if (!m_rv) chk("dout_idle", 64'(dout), 64'(0));
    end
    @(posedge clk);
    if (rs) begin
      mq.delete();
      mfp = 1'b0;
      minit = 1'b1;
    end else begin
      if (m_rd) repeat ((n < OL) ? n : OL) void'(mq.pop_front());
      if (m_wr)
        for (int j = 0; j < IL; j++) mq.push_back(d[(IL-1-j)*PW +: PW]);
      if (mfp) mfp = (mq.size() != 0);
      else mfp = e;
    end
    #1;
  endtask

  task automatic wr(input logic [23:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic reset2();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    @(posedge clk);
    #1;

    // reset
    reset2();
    chk("rst_count", 64'(count), 0);
    chk("rst_rd_vld", 64'(rd_vld), 0);
    chk("rst_wr_vld", 64'(wr_vld), 1);
    chk("rst_dout", 64'(dout), 0);

    // packing
    wr(24'h010203); wr(24'h040506); wr(24'h070809); wr(24'h0A0B0C);
    chk("pack_count", 64'(count), 12);
    chk("pack_w0", 64'(dout), 64'h01020304);
    rd();
    chk("pack_w1", 64'(dout), 64'h05060708);
    rd();
    chk("pack_w2", 64'(dout), 64'h090A0B0C);
    rd();
    chk("pack_empty", 64'(count), 0);

    // full
    reset2();
    for (int i = 0; i < 5; i++) wr(24'($urandom));
    chk("full_count", 64'(count), 15);
    chk("full_wr_vld", 64'(wr_vld), 0);
    wr(24'hDEAD00);
    chk("full_ignored", 64'(count), 15);
    rd();
    chk("full_pop_count", 64'(count), 11);
    chk("full_pop_wr_vld", 64'(wr_vld), 1);

    // concurrency across the wrap: offset pointers by a 3-lane flush
    reset2();
    wr(24'hA1A2A3);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("off_word", 64'({rd_last, dout}), 64'h1_A1A2A300);
    rd();
    chk("off_count", 64'(count), 0);
    wr(24'h010203); wr(24'h040506); wr(24'h070809); wr(24'h0A0B0C);
    rd();
    chk("conc_count8", 64'(count), 8);
    step(1'b1, 24'h0D0E0F, 1'b1, 1'b0, 1'b0);
    chk("conc_count7", 64'(count), 7);
    chk("conc_head", 64'(dout), 64'h090A0B0C);
    rd();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("conc_wrap", 64'({rd_last, dout}), 64'h1_0D0E0F00);
    rd();
    chk("conc_empty", 64'(count), 0);

    // flush
    reset2();
    wr(24'h010203); wr(24'h040506);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("flush_w0", 64'({rd_last, dout}), 64'h0_01020304);
    chk("flush_wr_vld", 64'(wr_vld), 0);
    rd();
    chk("flush_w1", 64'({rd_last, dout}), 64'h1_05060000);
    rd();
    chk("flush_count", 64'(count), 0);
    chk("flush_done_wr_vld", 64'(wr_vld), 1);

    // empty flush emits nothing and ends after one cycle
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("eflush_rd_vld", 64'(rd_vld), 0);
    chk("eflush_wr_vld", 64'(wr_vld), 0);
    rd();
    chk("eflush_end", 64'(wr_vld), 1);

    // reset during flush
    reset2();
    wr(24'h111213); wr(24'h141516); wr(24'h171819);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    rd();
    chk("mid_count5", 64'(count), 5);
    step(1'b1, 24'h202122, 1'b1, 1'b1, 1'b1);
    chk("mid_count", 64'(count), 0);
    chk("mid_rd_vld", 64'(rd_vld), 0);
    chk("mid_wr_vld", 64'(wr_vld), 1);
    chk("mid_dout", 64'(dout), 0);

    // random traffic: read-heavy, then write-heavy
    for (int k = 0; k < 1500; k++)
      step($urandom_range(0, 2) != 0, 24'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 199) == 0);
    for (int k = 0; k < 1500; k++)
      step($urandom_range(0, 3) != 0, 24'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 299) == 0);

    chk("sb_drained", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
